// File: rtl/timer_pkg.sv
// Shared definitions for the timer device: FSM encoding, register map, CTRL layout, MODE codes.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Only 01 reloads; both 1x encodings fall back to one-shot behaviour.
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage

// File: rtl/timer_dev.sv
// Bus-mapped down-counter with one-shot/auto-reload modes and a maskable interrupt.
// Zero-cycle combinational read mux; writes take effect on the next clk edge, no stalls.
module timer_dev
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dev_sel,
  input  logic        dev_we,
  input  logic [1:0]  dev_addr,
  input  logic [31:0] dev_wd,
  output logic [31:0] dev_rd,
  output logic        irq
);

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irqf_q, irqf_d;
  logic        irqf_drop_q, irqf_drop_d;

  logic wr_ctrl;
  logic wr_preset;
  logic cpu_clr;
  logic hw_set;
  logic hw_en_clr;

  assign wr_ctrl   = dev_sel && dev_we && (dev_addr == ADDR_CTRL);
  assign wr_preset = dev_sel && dev_we && (dev_addr == ADDR_PRESET);
  assign cpu_clr   = wr_ctrl || wr_preset;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hw_set    = 1'b0;
    hw_en_clr = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else begin
          if (count_q != 32'd0) count_d = count_q - 32'd1;
          // Enter INT on the edge COUNT reaches zero so a reload period is PRESET+2.
          if (count_q <= 32'd1) state_d = ST_INT;
        end
      end
      ST_INT: begin
        hw_set = 1'b1;
        if (is_reload(mode_q)) begin
          state_d = ST_LOAD;
        end else begin
          hw_en_clr = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A CPU write to CTRL overrides the hardware EN clear in the same cycle.
  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    if (hw_en_clr) en_d = 1'b0;
    if (wr_ctrl) begin
      en_d   = dev_wd[CTRL_EN_BIT];
      mode_d = dev_wd[CTRL_MODE_MSB:CTRL_MODE_LSB];
      im_d   = dev_wd[CTRL_IM_BIT];
    end
    if (wr_preset) preset_d = dev_wd;
  end

  // Setting wins over a same-cycle clear; the clear is then replayed one cycle later
  // through irqf_drop, which also produces the single-cycle reload pulse.
  always_comb begin
    irqf_d      = irqf_q;
    irqf_drop_d = 1'b0;
    if (irqf_drop_q) irqf_d = 1'b0;
    if (cpu_clr)     irqf_d = 1'b0;
    if (hw_set) begin
      irqf_d      = 1'b1;
      irqf_drop_d = is_reload(mode_q) || cpu_clr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      mode_q      <= MODE_ONESHOT;
      im_q        <= 1'b0;
      preset_q    <= 32'd0;
      count_q     <= 32'd0;
      irqf_q      <= 1'b0;
      irqf_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      mode_q      <= mode_d;
      im_q        <= im_d;
      preset_q    <= preset_d;
      count_q     <= count_d;
      irqf_q      <= irqf_d;
      irqf_drop_q <= irqf_drop_d;
    end
  end

  always_comb begin
    dev_rd = 32'd0;
    unique case (dev_addr)
      ADDR_CTRL:   dev_rd = {28'd0, im_q, mode_q, en_q};
      ADDR_PRESET: dev_rd = preset_q;
      ADDR_COUNT:  dev_rd = count_q;
      ADDR_RSVD:   dev_rd = 32'd0;
      default:     dev_rd = 32'd0;
    endcase
  end

  assign irq = irqf_q && im_q;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: vector table for the register/FSM sequences plus async reset checks.
module tb_timer_dev;

  logic        clk;
  logic        rst_n;
  logic        dev_sel;
  logic        dev_we;
  logic [1:0]  dev_addr;
  logic [31:0] dev_wd;
  logic [31:0] dev_rd;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
    logic        win;
    string       tag;
  } vec_t;

  vec_t vt[$];

  timer_dev dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dev_sel  (dev_sel),
    .dev_we   (dev_we),
    .dev_addr (dev_addr),
    .dev_wd   (dev_wd),
    .dev_rd   (dev_rd),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic vw(input logic [1:0] a, input logic [31:0] wd, input logic [31:0] erd,
                    input logic eirq, input string tag);
    vec_t v;
    v.sel = 1'b1; v.we = 1'b1; v.addr = a; v.wd = wd;
    v.exp_rd = erd; v.exp_irq = eirq; v.win = 1'b0; v.tag = tag;
    vt.push_back(v);
  endtask

  task automatic vr(input logic [1:0] a, input logic [31:0] erd, input logic eirq,
                    input logic win, input string tag);
    vec_t v;
    v.sel = 1'b0; v.we = 1'b0; v.addr = a; v.wd = 32'd0;
    v.exp_rd = erd; v.exp_irq = eirq; v.win = win; v.tag = tag;
    vt.push_back(v);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
    dev_sel  = 1'b1;
    dev_we   = 1'b1;
    dev_addr = a;
    dev_wd   = wd;
    @(posedge clk);
    #1;
    dev_sel = 1'b0;
    dev_we  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int irq_highs;
    logic found;
    logic [31:0] ar_cnt [13];
    logic        ar_irq [13];

    rst_n    = 1'b0;
    dev_sel  = 1'b0;
    dev_we   = 1'b0;
    dev_addr = 2'd0;
    dev_wd   = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    check1("reset_irq", irq, 1'b0);
    for (int a = 0; a < 4; a++) begin
      dev_addr = a[1:0];
      #1;
      check32($sformatf("reset_rd_addr%0d", a), dev_rd, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    dev_addr = 2'd2;
    #1;
    check32("post_release_count", dev_rd, 32'd0);

    // One-shot: PRESET=5, CTRL=EN|IM.
    vw(2'd1, 32'd5, 32'd5, 1'b0, "os_preset");
    vw(2'd0, 32'h9, 32'h9, 1'b0, "os_ctrl");
    vr(2'd2, 32'd0, 1'b0, 1'b0, "os_load");
    vr(2'd2, 32'd5, 1'b0, 1'b0, "os_c5");
    vr(2'd2, 32'd4, 1'b0, 1'b0, "os_c4");
    vr(2'd2, 32'd3, 1'b0, 1'b0, "os_c3");
    vr(2'd2, 32'd2, 1'b0, 1'b0, "os_c2");
    vr(2'd2, 32'd1, 1'b0, 1'b0, "os_c1");
    vr(2'd2, 32'd0, 1'b0, 1'b0, "os_c0_int");
    vr(2'd0, 32'h8, 1'b1, 1'b0, "os_en_clr");
    vr(2'd2, 32'd0, 1'b1, 1'b0, "os_irq_hold");
    vr(2'd0, 32'h8, 1'b1, 1'b0, "os_irq_hold2");
    // IRQ clear by PRESET write; no restart without EN.
    vw(2'd1, 32'd3, 32'd3, 1'b0, "clr_preset");
    vr(2'd2, 32'd0, 1'b0, 1'b0, "clr_idle1");
    vr(2'd2, 32'd0, 1'b0, 1'b0, "clr_idle2");
    vr(2'd2, 32'd0, 1'b0, 1'b0, "clr_idle3");
    vr(2'd0, 32'h8, 1'b0, 1'b0, "clr_ctrl");
    // Zero preset, masked interrupt.
    vw(2'd1, 32'd0, 32'd0, 1'b0, "z_preset");
    vw(2'd0, 32'h1, 32'h1, 1'b0, "z_ctrl");
    vr(2'd0, 32'h1, 1'b0, 1'b0, "z_load");
    vr(2'd2, 32'd0, 1'b0, 1'b0, "z_cnt");
    vr(2'd0, 32'h1, 1'b0, 1'b0, "z_int");
    vr(2'd0, 32'h0, 1'b0, 1'b0, "z_en_clr");
    vr(2'd3, 32'd0, 1'b0, 1'b0, "z_rsvd");
    // Auto-reload: PRESET=2, CTRL=EN|MODE01|IM, period 4.
    vw(2'd1, 32'd2, 32'd2, 1'b0, "ar_preset");
    vw(2'd0, 32'hB, 32'hB, 1'b0, "ar_ctrl");
    ar_cnt = '{32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0};
    ar_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 13; k++)
      vr(2'd2, ar_cnt[k], ar_irq[k], (k < 10), $sformatf("ar_e%0d", k + 1));
    // EN=0 during CNT freezes COUNT.
    vw(2'd0, 32'h0, 32'h0, 1'b0, "ar_stop");
    vr(2'd2, 32'd2, 1'b0, 1'b0, "frz1");
    vr(2'd2, 32'd2, 1'b0, 1'b0, "frz2");
    // Restart from LOAD with new preset, then CTRL write collides with INT.
    vw(2'd1, 32'd3, 32'd3, 1'b0, "col_preset");
    vw(2'd0, 32'h9, 32'h9, 1'b0, "col_ctrl");
    vr(2'd2, 32'd2, 1'b0, 1'b0, "col_load");
    vr(2'd2, 32'd3, 1'b0, 1'b0, "col_c3");
    vr(2'd2, 32'd2, 1'b0, 1'b0, "col_c2");
    vr(2'd2, 32'd1, 1'b0, 1'b0, "col_c1");
    vr(2'd2, 32'd0, 1'b0, 1'b0, "col_int");
    vw(2'd0, 32'h9, 32'h9, 1'b1, "col_write");
    vr(2'd2, 32'd0, 1'b0, 1'b0, "col_drop");
    vr(2'd2, 32'd3, 1'b0, 1'b0, "col_reload");
    vw(2'd2, 32'h55, 32'd2, 1'b0, "cnt_wr_ign");
    vw(2'd3, 32'hFFFF_FFFF, 32'd0, 1'b0, "rsvd_wr");
    vr(2'd2, 32'd0, 1'b0, 1'b0, "col_int2");
    vr(2'd0, 32'h8, 1'b1, 1'b0, "col_end");
    vr(2'd1, 32'd3, 1'b1, 1'b0, "preset_kept");

    pulses = 0;
    for (int i = 0; i < vt.size(); i++) begin
      dev_sel  = vt[i].sel;
      dev_we   = vt[i].we;
      dev_addr = vt[i].addr;
      dev_wd   = vt[i].wd;
      @(posedge clk);
      #1;
      dev_sel = 1'b0;
      dev_we  = 1'b0;
      check32({vt[i].tag, "_rd"}, dev_rd, vt[i].exp_rd);
      check1({vt[i].tag, "_irq"}, irq, vt[i].exp_irq);
      if (vt[i].win && irq === 1'b1) pulses++;
    end
    check32("ar_pulses_in_10", pulses, 32'd2);

    // Asynchronous reset in the middle of a count.
    bus_write(2'd1, 32'd20);
    bus_write(2'd0, 32'h9);
    dev_addr = 2'd2;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      #1;
      if (dev_rd === 32'd7) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check1("reach_count7", found, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("arst_irq", irq, 1'b0);
    for (int a = 0; a < 4; a++) begin
      dev_addr = a[1:0];
      #1;
      check32($sformatf("arst_rd_addr%0d", a), dev_rd, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    irq_highs = 0;
    dev_addr = 2'd2;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (irq !== 1'b0 || dev_rd !== 32'd0) irq_highs++;
    end
    check32("post_reset_quiet_cycles", irq_highs, 32'd0);
    dev_addr = 2'd0;
    #1;
    check32("post_reset_ctrl", dev_rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port dev_sel, input, 1 bit: bridge chip-select; the access targets this device.
REQ-004 SHALL have port dev_we, input, 1 bit: write strobe; only effective when dev_sel=1.
REQ-005 SHALL have port dev_addr, input, 2 bits: word offset; 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-006 SHALL have port dev_wd, input, 32 bits: write data from the bridge.
REQ-007 SHALL have port dev_rd, output, 32 bits: read data returned to the bridge and muxed into CPU writeback as bridge read data.
REQ-008 SHALL have port irq, output, 1 bit: interrupt request to CP0.

Function
REQ-009 SHALL perform a write to the addressed register on a clock edge when dev_sel=1 and dev_we=1.
REQ-010 SHALL implement CTRL as follows: bit0 EN (enable), bits2:1 MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask, 1=enabled), bits31:4 read as 0.
REQ-011 SHALL make PRESET a 32-bit read/write register.
REQ-012 SHALL make COUNT read-only; writes to offset 2 and offset 3 are ignored.
REQ-013 SHALL drive dev_rd combinationally from dev_addr with zero-cycle latency, regardless of dev_sel: CTRL zero-extended from bits3:0, PRESET, COUNT, or 0 for offset 3.
REQ-014 SHALL implement an FSM with states IDLE, LOAD, CNT and INT.
REQ-015 SHALL, in IDLE, move to LOAD on the next edge if EN=1; otherwise stay in IDLE.
REQ-016 SHALL, in LOAD, set COUNT to PRESET and move to CNT.
REQ-017 SHALL, in CNT with EN=0, move to IDLE with COUNT frozen.
REQ-018 SHALL, in CNT with COUNT>0, decrement COUNT by 1 per cycle, wrapping-free.
REQ-019 SHALL, in CNT with COUNT=0, move to INT.
REQ-020 SHALL, with PRESET=0, take the path LOAD -> CNT -> INT, so that INT is entered 2 cycles after LOAD.
REQ-021 SHALL, in INT with MODE=00, set the sticky flag IRQF, clear EN in hardware, and move to IDLE.
REQ-022 SHALL, in INT with MODE=01, pulse IRQF for exactly one cycle and move to LOAD (auto-reload).
REQ-023 SHALL drive irq = IRQF AND IM, registered with no combinational path from dev_* inputs.
REQ-024 SHALL clear the sticky IRQF on any CPU write to CTRL or PRESET.
REQ-025 SHALL let a CPU write to CTRL in the same cycle as the hardware EN-clear in INT take priority: the written value is kept; IRQF is still set and then cleared by the write rule from the next cycle.
REQ-026 SHALL apply a PRESET write during CNT only at the next LOAD; the running COUNT is unaffected.
REQ-027 SHALL, on a CTRL write of EN=0 during CNT, freeze COUNT; a later EN=1 restarts from LOAD, not a resume.
REQ-028 SHALL use period = PRESET+2 cycles from LOAD to LOAD in auto-reload mode.

Reset
REQ-029 SHALL, while rst_n=0 (asynchronous), set CTRL=0, PRESET=0, COUNT=0, IRQF=0 and state=IDLE, giving irq=0 and dev_rd=0.
REQ-030 SHALL abort any count in progress on reset mid-operation, with no irq generated after release.
REQ-031 SHALL leave the FSM in IDLE on the first edge after release unless EN is written.

Structure
REQ-032 SHALL place the FSM state encoding, register offsets (CTRL/PRESET/COUNT), CTRL bit positions and MODE codes in a shared package timer_pkg.
REQ-033 SHALL be a single flat module with no sub-module; the read mux is inline.

Verification
REQ-034 SHALL verify one-shot: PRESET=5, CTRL=0x9 -> COUNT reads 5,4,3,2,1,0 on consecutive cycles; irq=1 from the INT+1 edge and held; CTRL reads 0x8 (EN cleared).
REQ-035 SHALL verify IRQ clear: after REQ-034, write PRESET=3 -> irq=0 next cycle; no new count starts until EN=1 is written.
REQ-036 SHALL verify auto-reload: PRESET=2, CTRL=0xB -> irq pulses 1 cycle high every 4 cycles (PRESET+2); 10 cycles yield 2 pulses.
REQ-037 SHALL verify masking and zero preset: PRESET=0, CTRL=0x1 -> INT reached 2 cycles after LOAD; irq stays 0; CTRL reads 0x0.
REQ-038 SHALL verify write collision: write CTRL=0x9 in the exact INT cycle -> EN remains 1 and the FSM reloads; a COUNT write is ignored (COUNT unchanged); offset 3 reads 0.
REQ-039 SHALL verify reset: assert rst_n=0 mid-count at COUNT=7 -> all registers 0 and irq=0 immediately without a clock; no irq after release.
